// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - UART-to-ALU sequencer: collects A, B and opcode, sends back result (and flags byte when FLAGS_TX_EN is defined)
module uart_alu_interface #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [DATA_WIDTH-1:0]   i_rx_data,
    input  logic                    i_rx_done,
    input  logic                    i_tx_done,
    input  logic [DATA_WIDTH-1:0]   i_result,
    input  logic                    i_zero,
    input  logic                    i_carry,
    input  logic                    i_overflow,
    input  logic                    i_negative,
    input  logic                    i_exception,
    output logic [DATA_WIDTH-1:0]   o_operandA,
    output logic [DATA_WIDTH-1:0]   o_operandB,
    output logic [OPCODE_WIDTH-1:0] o_opcode,
    output logic [DATA_WIDTH-1:0]   o_tx_data,
    output logic                    o_tx_start,
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        S_OPA      = 3'd0,
        S_OPB      = 3'd1,
        S_OPC      = 3'd2,
        S_CALC     = 3'd3,
        S_TX_RES   = 3'd4,
        S_WAIT_RES = 3'd5,
        S_TX_FLG   = 3'd6,
        S_WAIT_FLG = 3'd7
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_operand_a;
    logic [DATA_WIDTH-1:0]   r_operand_b;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_start;
    logic                    r_busy;

`ifdef FLAGS_TX_EN
    logic [4:0]              r_flags;
    logic [DATA_WIDTH-1:0]   w_flags_byte;

    always_comb begin
        w_flags_byte      = '0;
        w_flags_byte[4:0] = r_flags;
    end
`else
    logic                    w_unused_flags;
    assign w_unused_flags = ^{i_zero, i_carry, i_overflow, i_negative, i_exception};
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_OPA;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef FLAGS_TX_EN
            r_flags     <= '0;
`endif
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_OPA: if (i_rx_done) begin
                    r_operand_a <= i_rx_data;
                    r_state     <= S_OPB;
                end
                S_OPB: if (i_rx_done) begin
                    r_operand_b <= i_rx_data;
                    r_state     <= S_OPC;
                end
                S_OPC: if (i_rx_done) begin
                    r_opcode <= i_rx_data[OPCODE_WIDTH-1:0];
                    r_busy   <= 1'b1;
                    r_state  <= S_CALC;
                end
                // Start is raised on the way into S_TX_RES so the pulse lines up with that state.
                S_CALC: begin
                    r_tx_data  <= i_result;
                    r_tx_start <= 1'b1;
`ifdef FLAGS_TX_EN
                    r_flags    <= {i_exception, i_negative, i_overflow, i_carry, i_zero};
`endif
                    r_state    <= S_TX_RES;
                end
                S_TX_RES: r_state <= S_WAIT_RES;
                S_WAIT_RES: if (i_tx_done) begin
`ifdef FLAGS_TX_EN
                    r_state <= S_TX_FLG;
`else
                    r_busy  <= 1'b0;
                    r_state <= S_OPA;
`endif
                end
`ifdef FLAGS_TX_EN
                S_TX_FLG: begin
                    r_tx_data  <= w_flags_byte;
                    r_tx_start <= 1'b1;
                    r_state    <= S_WAIT_FLG;
                end
                S_WAIT_FLG: if (i_tx_done) begin
                    r_busy  <= 1'b0;
                    r_state <= S_OPA;
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_OPA;
                end
            endcase
        end
    end

    assign o_operandA = r_operand_a;
    assign o_operandB = r_operand_b;
    assign o_opcode   = r_opcode;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - directed bench with ALU model and tx-byte scoreboard
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic [7:0] i_result;
    logic       i_zero, i_carry, i_overflow, i_negative, i_exception;
    logic [7:0] o_operandA, o_operandB, o_tx_data;
    logic [3:0] o_opcode;
    logic       o_tx_start, o_busy;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb_q[$];
    logic [7:0] last_flags;

    always #5 clk = ~clk;

    uart_alu_interface #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
        .i_result(i_result), .i_zero(i_zero), .i_carry(i_carry),
        .i_overflow(i_overflow), .i_negative(i_negative), .i_exception(i_exception),
        .o_operandA(o_operandA), .o_operandB(o_operandB), .o_opcode(o_opcode),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .o_busy(o_busy)
    );

    // Reference ALU: opcode 8 adds, opcode A subtracts; flags = {exc,neg,ov,carry,zero}.
    function automatic logic [7:0] alu_res(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'h8:    return a + b;
            4'hA:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] alu_flags(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0] s;
        logic [7:0] r;
        logic       c, v;
        r = alu_res(a, b, op);
        c = 1'b0;
        v = 1'b0;
        if (op == 4'h8) begin
            s = {1'b0, a} + {1'b0, b};
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end else if (op == 4'hA) begin
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end
        return {3'b000, 1'b0, r[7], v, c, (r == 8'h00)};
    endfunction

    logic [7:0] w_model_flags;
    assign i_result      = alu_res(o_operandA, o_operandB, o_opcode);
    assign w_model_flags = alu_flags(o_operandA, o_operandB, o_opcode);
    assign i_zero        = w_model_flags[0];
    assign i_carry       = w_model_flags[1];
    assign i_overflow    = w_model_flags[2];
    assign i_negative    = w_model_flags[3];
    assign i_exception   = w_model_flags[4];

    always @(negedge clk) begin
        if (o_tx_start) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $error("FAIL sb_unexpected_tx observed=%0h expected=none", o_tx_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb_q.pop_front();
                assert (o_tx_data === exp_b) else begin
                    failures++;
                    $error("FAIL sb_tx_data observed=%0h expected=%0h", o_tx_data, exp_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input bit spur);
        logic [7:0] exp_r;
        exp_r      = alu_res(a, b, op[3:0]);
        last_flags = alu_flags(a, b, op[3:0]);
        sb_q.push_back(exp_r);
        send_rx(a);
        if (spur) begin
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
            chk("spur_tx_start", o_tx_start, 1'b0);
            chk("spur_busy", o_busy, 1'b0);
        end
        send_rx(b);
        send_rx(op);
        chk("opA", o_operandA, a);
        chk("opB", o_operandB, b);
        chk("opcode", o_opcode, op[3:0]);
        chk("busy_calc", o_busy, 1'b1);
        chk("start_n1", o_tx_start, 1'b0);
        tick();
        chk("start_n2", o_tx_start, 1'b1);
        chk("txdata_n2", o_tx_data, exp_r);
        tick();
        chk("start_n3", o_tx_start, 1'b0);
        chk("busy_wait", o_busy, 1'b1);
    endtask

    task automatic done_tx(input bit with_rx);
`ifdef FLAGS_TX_EN
        sb_q.push_back(last_flags);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("flg_start_m1", o_tx_start, 1'b0);
        chk("flg_busy_m1", o_busy, 1'b1);
        tick();
        chk("flg_start_m2", o_tx_start, 1'b1);
        chk("flg_data_m2", o_tx_data, last_flags);
        tick();
        chk("flg_start_m3", o_tx_start, 1'b0);
`endif
        i_tx_done = 1'b1;
        i_rx_done = with_rx;
        i_rx_data = 8'h55;
        tick();
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        chk("done_busy", o_busy, 1'b0);
        chk("done_start", o_tx_start, 1'b0);
    endtask

    initial begin
        i_reset   = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        tick();
        tick();
        chk("rst_opA", o_operandA, 8'h00);
        chk("rst_opB", o_operandB, 8'h00);
        chk("rst_opcode", o_opcode, 4'h0);
        chk("rst_txdata", o_tx_data, 8'h00);
        chk("rst_start", o_tx_start, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        i_reset = 1'b0;
        tick();

        frame(8'h05, 8'h03, 8'h08, 1'b0);
        done_tx(1'b0);

        frame(8'h01, 8'h03, 8'hFA, 1'b1);
        done_tx(1'b0);

        frame(8'h40, 8'h40, 8'h08, 1'b0);
        done_tx(1'b0);

        frame(8'h02, 8'h05, 8'h08, 1'b0);
        done_tx(1'b1);
        frame(8'h01, 8'h02, 8'h08, 1'b0);
        done_tx(1'b0);

        frame(8'h07, 8'h01, 8'h08, 1'b0);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("wrst_opA", o_operandA, 8'h00);
        chk("wrst_opB", o_operandB, 8'h00);
        chk("wrst_opcode", o_opcode, 4'h0);
        chk("wrst_txdata", o_tx_data, 8'h00);
        chk("wrst_start", o_tx_start, 1'b0);
        chk("wrst_busy", o_busy, 1'b0);
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        tick();
        chk("postrst_start", o_tx_start, 1'b0);
        chk("postrst_busy", o_busy, 1'b0);

        frame(8'h03, 8'h04, 8'h08, 1'b0);
        done_tx(1'b0);
        tick();
        tick();

        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Sequencing stage between the UART receiver/transmitter pair and the ALU. It collects three received bytes (operand A, operand B, opcode) into registers that drive the ALU inputs, captures the ALU result one cycle after the opcode arrives, and hands the result byte to the UART transmitter with a start/done handshake. It then returns to waiting for the next operand A.

## Interface
- DATA_WIDTH, 8: width of operands, result and UART data words; must be ≥ 5.
- OPCODE_WIDTH, 4: width of the opcode driven to the ALU.

- i_clock  in  1  system clock, all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  DATA_WIDTH  byte from UART receiver, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, new received byte
- i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
- i_result  in  DATA_WIDTH  ALU result (combinational from o_operandA/B, o_opcode)
- i_zero, i_carry, i_overflow, i_negative, i_exception  in  1 each  ALU flags
- o_operandA  out  DATA_WIDTH  registered ALU operand A
- o_operandB  out  DATA_WIDTH  registered ALU operand B
- o_opcode  out  OPCODE_WIDTH  registered ALU opcode (low bits of received byte)
- o_tx_data  out  DATA_WIDTH  byte for transmitter, registered
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
- o_busy  out  1  high from opcode capture until final i_tx_done is accepted

## Operation
- States: S_OPA, S_OPB, S_OPC, S_CALC, S_TX_RES, S_WAIT_RES, S_TX_FLG, S_WAIT_FLG.
- S_OPA: on i_rx_done, o_operandA <= i_rx_data, go S_OPB. S_OPB: same for o_operandB, go S_OPC.
- S_OPC: on i_rx_done, o_opcode <= i_rx_data[OPCODE_WIDTH-1:0] (upper bits discarded), go S_CALC.
- S_CALC (one cycle, ALU settles): o_tx_data <= i_result; flags latched internally; go S_TX_RES.
- S_TX_RES (one cycle): o_tx_start=1; go S_WAIT_RES.
- S_WAIT_RES: on i_tx_done, go S_TX_FLG if FLAGS_TX_EN is defined, else S_OPA.
- S_TX_FLG: o_tx_data <= flags byte, o_tx_start=1, go S_WAIT_FLG. S_WAIT_FLG: on i_tx_done go S_OPA.
- Flags byte: bit0 zero, bit1 carry, bit2 overflow, bit3 negative, bit4 exception, remaining bits 0.
- Operand/opcode registers hold their value until overwritten by the next frame; they are never cleared except by reset.
- i_rx_done in any state other than S_OPA/S_OPB/S_OPC: byte dropped, no state change.
- i_tx_done outside S_WAIT_RES/S_WAIT_FLG: ignored.
- i_rx_done and i_tx_done in the same cycle in S_WAIT_*: rx byte dropped, tx_done honoured.
- No timeout: the block waits indefinitely in any S_OP* or S_WAIT_* state.

## Timing
- Reset (synchronous): state S_OPA; o_operandA, o_operandB, o_opcode, o_tx_data = 0; o_tx_start = 0; o_busy = 0; latched flags = 0. Reset during any state, including mid-transmit, aborts the frame; o_tx_start is 0 from the cycle after reset is sampled.
- Opcode i_rx_done in cycle n: o_opcode valid cycle n+1 (S_CALC); o_tx_data = result and o_tx_start = 1 in cycle n+2; o_tx_start low in n+3.
- o_busy = 1 from cycle n+1 until the cycle after the final accepted i_tx_done.
- Flags byte (when enabled): i_tx_done for result in cycle m -> o_tx_start=1 with flags byte in cycle m+2.
- o_tx_start is exactly one cycle wide per byte; o_tx_data is stable from the start pulse until the next S_CALC/S_TX_FLG update.

## Configuration
- FLAGS_TX_EN defined: each frame transmits two bytes, result then flags byte; S_TX_FLG/S_WAIT_FLG present.
- FLAGS_TX_EN undefined: only the result byte is transmitted; S_TX_FLG/S_WAIT_FLG and the flag latch are omitted; i_tx_done in S_WAIT_RES returns to S_OPA.

## Test plan
- Reset, then rx 0x05, 0x03, 0x08; bench ALU model returns i_result=0x08 -> o_operandA=0x05, o_operandB=0x03, o_opcode=0x8, o_tx_start pulse with o_tx_data=0x08 two cycles after the opcode byte.
- Opcode byte 0xFA -> o_opcode=0xA (upper nibble discarded); i_result=0xFE transmitted.
- FLAGS_TX_EN: i_result=0x80, flags i_negative=1, i_overflow=1, others 0; after result i_tx_done -> second o_tx_start with o_tx_data=0x0C.
- Extra i_rx_done (0x55) during S_WAIT_RES, same cycle as i_tx_done -> byte dropped, block returns to S_OPA; next frame 0x01,0x02,0x08 captured correctly.
- i_reset asserted in S_WAIT_RES -> all outputs 0 next cycle, later i_tx_done ignored, next three rx bytes start a fresh frame.
- Spurious i_tx_done in S_OPB -> no state change; o_tx_start stays 0.
